// File: rtl/cpu_6502_fetch_unit.sv
// 6502 instruction fetch stage: reads opcode plus 0-2 operand bytes, decodes length, hands a bundle to the decoder.
// Optional build macro FETCH_ILLEGAL_TRAP_EN: cc=11 opcodes are flagged illegal and fetch halts until redirect.
module cpu_6502_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h8000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [15:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [7:0]  instr_opcode_o,
  output logic [7:0]  instr_op1_o,
  output logic [7:0]  instr_op2_o,
  output logic [1:0]  instr_len_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_illegal_o
);

  localparam int unsigned PC_W   = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 2;

  typedef enum logic [2:0] {
    ST_FETCH0,
    ST_CAP0,
    ST_CAP1,
    ST_CAP2,
    ST_VALID,
    ST_HALT
  } state_t;

  state_t              r_state, w_next_state;
  logic [PC_W-1:0]     r_pc, w_pc_next;
  logic [PC_W-1:0]     r_instr_pc, w_instr_pc_next;
  logic [DATA_W-1:0]   r_opcode, w_opcode_next;
  logic [DATA_W-1:0]   r_op1, w_op1_next;
  logic [DATA_W-1:0]   r_op2, w_op2_next;
  logic [LEN_W-1:0]    r_len, w_len_next;
  logic                r_valid;
  logic                w_mem_req;
  logic [PC_W-1:0]     w_mem_addr;
  logic [LEN_W-1:0]    w_dec_len;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic                r_illegal, w_illegal_next;
`endif

  // Instruction length from the aaa/bbb/cc opcode grouping
  function automatic logic [1:0] f_instr_len(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] cc;
    logic [1:0] len;
    bbb = op[4:2];
    cc  = op[1:0];
    len = 2'd2;
    case (cc)
      2'b01: begin
        if (bbb inside {3'b011, 3'b110, 3'b111}) len = 2'd3;
      end
      2'b10: begin
        if (bbb == 3'b010 || op == 8'h9A || op == 8'hBA) len = 2'd1;
        else if (bbb inside {3'b011, 3'b111})            len = 2'd3;
      end
      2'b00: begin
        if (op inside {8'h00, 8'h40, 8'h60})       len = 2'd1;
        else if (op == 8'h20)                      len = 2'd3;
        else if (bbb == 3'b100)                    len = 2'd2;
        else if (bbb inside {3'b010, 3'b110})      len = 2'd1;
        else if (bbb inside {3'b011, 3'b111})      len = 2'd3;
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  assign w_dec_len = f_instr_len(mem_rdata_i);

  // Next-state, datapath next values and memory request
  always_comb begin
    w_next_state    = r_state;
    w_pc_next       = r_pc;
    w_instr_pc_next = r_instr_pc;
    w_opcode_next   = r_opcode;
    w_op1_next      = r_op1;
    w_op2_next      = r_op2;
    w_len_next      = r_len;
    w_mem_req       = 1'b0;
    w_mem_addr      = r_pc;
`ifdef FETCH_ILLEGAL_TRAP_EN
    w_illegal_next  = r_illegal;
`endif
    case (r_state)
      ST_FETCH0: begin
        w_mem_req    = 1'b1;
        w_mem_addr   = r_pc;
        w_next_state = ST_CAP0;
      end
      ST_CAP0: begin
        w_opcode_next   = mem_rdata_i;
        w_len_next      = w_dec_len;
        w_instr_pc_next = r_pc;
        w_op1_next      = '0;
        w_op2_next      = '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
        w_illegal_next  = (mem_rdata_i[1:0] == 2'b11);
`endif
        if (w_dec_len >= 2'd2) begin
          w_mem_req    = 1'b1;
          w_mem_addr   = r_pc + 16'd1;
          w_next_state = ST_CAP1;
        end else begin
          w_next_state = ST_VALID;
        end
      end
      ST_CAP1: begin
        w_op1_next = mem_rdata_i;
        if (r_len == 2'd3) begin
          w_mem_req    = 1'b1;
          w_mem_addr   = r_pc + 16'd2;
          w_next_state = ST_CAP2;
        end else begin
          w_next_state = ST_VALID;
        end
      end
      ST_CAP2: begin
        w_op2_next   = mem_rdata_i;
        w_next_state = ST_VALID;
      end
      ST_VALID: begin
        if (instr_ready_i) begin
          w_pc_next    = r_pc + PC_W'(r_len);
          w_next_state = ST_FETCH0;
`ifdef FETCH_ILLEGAL_TRAP_EN
          if (r_illegal) w_next_state = ST_HALT;
`endif
        end
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FETCH0;
    endcase
    // Redirect wins over everything, including a same-cycle handshake
    if (redirect_valid_i) begin
      w_next_state = ST_FETCH0;
      w_pc_next    = redirect_pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH0;
      r_pc       <= RESET_PC;
      r_instr_pc <= '0;
      r_opcode   <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_len      <= '0;
      r_valid    <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_pc_next;
      r_instr_pc <= w_instr_pc_next;
      r_opcode   <= w_opcode_next;
      r_op1      <= w_op1_next;
      r_op2      <= w_op2_next;
      r_len      <= w_len_next;
      r_valid    <= (w_next_state == ST_VALID);
`ifdef FETCH_ILLEGAL_TRAP_EN
      r_illegal  <= w_illegal_next;
`endif
    end
  end

  // Request must be issued in the cycle the opcode arrives, so it is decoded from state and read data
  assign mem_req_o      = w_mem_req;
  assign mem_addr_o     = w_mem_addr;
  assign instr_valid_o  = r_valid;
  assign instr_opcode_o = r_opcode;
  assign instr_op1_o    = r_op1;
  assign instr_op2_o    = r_op2;
  assign instr_len_o    = r_len;
  assign instr_pc_o     = r_instr_pc;
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign instr_illegal_o = r_illegal;
`else
  assign instr_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_6502_fetch_unit.sv
// Self-checking bench for cpu_6502_fetch_unit: vector table, directed corner sequences, random stream vs reference model.
module tb_cpu_6502_fetch_unit;

`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_rdata_i;
  logic        redirect_valid_i;
  logic [15:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [7:0]  instr_opcode_o, instr_op1_o, instr_op2_o;
  logic [1:0]  instr_len_o;
  logic [15:0] instr_pc_o;
  logic        instr_illegal_o;

  logic [7:0]  mem [0:65535];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  cpu_6502_fetch_unit #(.RESET_PC(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_opcode_o(instr_opcode_o), .instr_op1_o(instr_op1_o), .instr_op2_o(instr_op2_o),
    .instr_len_o(instr_len_o), .instr_pc_o(instr_pc_o), .instr_illegal_o(instr_illegal_o)
  );

  // Byte memory: data one cycle after request, garbage otherwise
  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
    else           mem_rdata_i <= 8'($urandom);
  end

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b0, b1, b2;
    logic [1:0]  len;
    logic [7:0]  op1, op2;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] pack(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] l, input logic [15:0] p, input logic il);
    return {o, a, b, l, p, il};
  endfunction

  function automatic logic [42:0] dut_bundle();
    return pack(instr_opcode_o, instr_op1_o, instr_op2_o, instr_len_o, instr_pc_o, instr_illegal_o);
  endfunction

  // Reference length: addressing-mode view of the opcode map
  function automatic int ref_len(input int op);
    int mode, grp;
    mode = (op >> 2) & 7;
    grp  = op & 3;
    if (grp == 3) return 1;
    if (grp == 0 && (op == 'h00 || op == 'h40 || op == 'h60)) return 1;
    if (op == 'h20) return 3;
    if (op == 'h9A || op == 'hBA) return 1;
    if (grp == 0 && mode == 4) return 2;
    if (grp != 1 && (mode == 2 || (grp == 0 && mode == 6))) return 1;
    if (mode == 3 || mode == 7 || (grp == 1 && mode == 6)) return 3;
    return 2;
  endfunction

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid_o && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(instr_valid_o), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_rst_state"}, {20'd0, instr_valid_o, dut_bundle()}, 64'd0);
    rst_n = 1'b1;
    check({tag, "_first_req"}, {mem_req_o, mem_addr_o}, {1'b1, 16'h8000});
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    redirect_pc_i = pc;
    redirect_valid_i = 1'b1;
    @(negedge clk);
    redirect_valid_i = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic [15:0] a1, a2, nxt;
    logic [15:0] addrs[$];
    logic [55:0] act_a, exp_a;
    logic        exp_ill, seen;
    int          cyc;
    v   = vecs[idx];
    a1  = v.pc + 16'd1;
    a2  = v.pc + 16'd2;
    nxt = v.pc + 16'(v.len);
    mem[v.pc] = v.b0;
    mem[a1]   = v.b1;
    mem[a2]   = v.b2;
    exp_ill = TRAP && (v.b0[1:0] == 2'b11);
    redirect_to(v.pc);
    cyc = 0;
    while (!instr_valid_o && cyc < 12) begin
      if (mem_req_o) addrs.push_back(mem_addr_o);
      @(negedge clk);
      cyc++;
    end
    check($sformatf("vec%0d_latency", idx), 64'(cyc), 64'(int'(v.len) + 1));
    act_a = {8'(addrs.size()), addrs.size() > 0 ? addrs[0] : 16'h0,
             addrs.size() > 1 ? addrs[1] : 16'h0, addrs.size() > 2 ? addrs[2] : 16'h0};
    exp_a = {8'(v.len), v.pc, v.len >= 2'd2 ? a1 : 16'h0, v.len == 2'd3 ? a2 : 16'h0};
    check($sformatf("vec%0d_addrs", idx), 64'(act_a), 64'(exp_a));
    check($sformatf("vec%0d_bundle", idx), 64'(dut_bundle()),
          64'(pack(v.b0, v.op1, v.op2, v.len, v.pc, exp_ill)));
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    if (exp_ill) begin
      seen = 1'b0;
      repeat (5) begin
        seen |= mem_req_o | instr_valid_o;
        @(negedge clk);
      end
      check($sformatf("vec%0d_halt_quiet", idx), 64'(seen), 64'd0);
    end else begin
      check($sformatf("vec%0d_next_req", idx), {mem_req_o, mem_addr_o}, {1'b1, nxt});
    end
  endtask

  initial begin
    logic [42:0] exp_b [3];
    logic [15:0] ref_pc, p1, p2;
    logic [7:0]  b, eo, ea, eb;
    int          got, hs, l;
    bit          rdy, rd, stable;
    logic [15:0] tgt;

    rst_n = 1'b0;
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 16'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;

    vecs[0]  = '{16'h8000, 8'hEA, 8'h11, 8'h22, 2'd1, 8'h00, 8'h00};
    vecs[1]  = '{16'h8000, 8'hA9, 8'h05, 8'hAD, 2'd2, 8'h05, 8'h00};
    vecs[2]  = '{16'h8002, 8'hAD, 8'h34, 8'h12, 2'd3, 8'h34, 8'h12};
    vecs[3]  = '{16'h8005, 8'h0A, 8'h33, 8'h44, 2'd1, 8'h00, 8'h00};
    vecs[4]  = '{16'h8100, 8'h20, 8'h00, 8'hC0, 2'd3, 8'h00, 8'hC0};
    vecs[5]  = '{16'h8200, 8'h60, 8'h55, 8'h66, 2'd1, 8'h00, 8'h00};
    vecs[6]  = '{16'h8210, 8'h00, 8'h55, 8'h66, 2'd1, 8'h00, 8'h00};
    vecs[7]  = '{16'h8220, 8'h40, 8'h55, 8'h66, 2'd1, 8'h00, 8'h00};
    vecs[8]  = '{16'h8230, 8'hD0, 8'hFE, 8'h77, 2'd2, 8'hFE, 8'h00};
    vecs[9]  = '{16'h8240, 8'h08, 8'h11, 8'h22, 2'd1, 8'h00, 8'h00};
    vecs[10] = '{16'h8250, 8'h18, 8'h11, 8'h22, 2'd1, 8'h00, 8'h00};
    vecs[11] = '{16'h8260, 8'h4C, 8'h34, 8'h12, 2'd3, 8'h34, 8'h12};
    vecs[12] = '{16'h8270, 8'h6C, 8'h00, 8'h90, 2'd3, 8'h00, 8'h90};
    vecs[13] = '{16'h8280, 8'h9A, 8'h11, 8'h22, 2'd1, 8'h00, 8'h00};
    vecs[14] = '{16'h8290, 8'hBA, 8'h11, 8'h22, 2'd1, 8'h00, 8'h00};
    vecs[15] = '{16'h82A0, 8'hBE, 8'h10, 8'h20, 2'd3, 8'h10, 8'h20};
    vecs[16] = '{16'h82B0, 8'hA2, 8'h7F, 8'h22, 2'd2, 8'h7F, 8'h00};
    vecs[17] = '{16'h82C0, 8'hB9, 8'h01, 8'h02, 2'd3, 8'h01, 8'h02};
    vecs[18] = '{16'h82D0, 8'h91, 8'h44, 8'h22, 2'd2, 8'h44, 8'h00};
    vecs[19] = '{16'h82E0, 8'hBC, 8'h01, 8'h02, 2'd3, 8'h01, 8'h02};
    vecs[20] = '{16'h82F0, 8'h24, 8'h44, 8'h22, 2'd2, 8'h44, 8'h00};
    vecs[21] = '{16'h8300, 8'hFF, 8'h11, 8'h22, 2'd1, 8'h00, 8'h00};
    vecs[22] = '{16'h8310, 8'h03, 8'h11, 8'h22, 2'd1, 8'h00, 8'h00};
    vecs[23] = '{16'hFFFE, 8'h4C, 8'h00, 8'h80, 2'd3, 8'h00, 8'h80};
    vecs[24] = '{16'hFFFF, 8'hA9, 8'h5A, 8'h00, 2'd2, 8'h5A, 8'h00};

    // Reset fetch of a NOP at the reset vector
    mem[16'h8000] = 8'hEA;
    do_reset("rst");
    @(negedge clk);
    check("rst_cycle2", {instr_valid_o, mem_req_o}, 2'b00);
    @(negedge clk);
    check("rst_bundle", {instr_valid_o, dut_bundle()},
          {1'b1, pack(8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000, 1'b0)});
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    check("rst_next_req", {mem_req_o, mem_addr_o}, {1'b1, 16'h8001});

    // Back-to-back stream with ready held high
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h05; mem[16'h8002] = 8'hAD;
    mem[16'h8003] = 8'h34; mem[16'h8004] = 8'h12; mem[16'h8005] = 8'h0A;
    exp_b[0] = pack(8'hA9, 8'h05, 8'h00, 2'd2, 16'h8000, 1'b0);
    exp_b[1] = pack(8'hAD, 8'h34, 8'h12, 2'd3, 16'h8002, 1'b0);
    exp_b[2] = pack(8'h0A, 8'h00, 8'h00, 2'd1, 16'h8005, 1'b0);
    do_reset("stream");
    instr_ready_i = 1'b1;
    got = 0;
    for (int n = 0; n < 30 && got < 3; n++) begin
      if (instr_valid_o) begin
        check($sformatf("stream_%0d", got), 64'(dut_bundle()), 64'(exp_b[got]));
        got++;
      end
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
    check("stream_count", 64'(got), 64'd3);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: bundle held, no requests, single pc advance on release
    mem[16'h9000] = 8'hAD; mem[16'h9001] = 8'h34; mem[16'h9002] = 8'h12; mem[16'h9003] = 8'hEA;
    redirect_to(16'h9000);
    wait_valid("bp");
    stable = 1'b1;
    repeat (10) begin
      if (!instr_valid_o || mem_req_o ||
          dut_bundle() != pack(8'hAD, 8'h34, 8'h12, 2'd3, 16'h9000, 1'b0)) stable = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", 64'(stable), 64'd1);
    instr_ready_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    check("bp_next_req", {mem_req_o, mem_addr_o}, {1'b1, 16'h9003});
    wait_valid("bp2");
    check("bp2_pc", 64'(instr_pc_o), 64'h9003);

    // Redirect during CAP1 of a 3-byte instruction
    mem[16'hA000] = 8'hAD; mem[16'hA001] = 8'h34; mem[16'hA002] = 8'h12; mem[16'hC000] = 8'hEA;
    redirect_to(16'hA000);
    repeat (2) @(negedge clk);
    redirect_pc_i = 16'hC000;
    redirect_valid_i = 1'b1;
    @(negedge clk);
    redirect_valid_i = 1'b0;
    check("redir_req", {instr_valid_o, mem_req_o, mem_addr_o}, {2'b01, 16'hC000});
    wait_valid("redir");
    check("redir_bundle", 64'(dut_bundle()), 64'(pack(8'hEA, 8'h00, 8'h00, 2'd1, 16'hC000, 1'b0)));
    // Redirect coinciding with a handshake
    instr_ready_i = 1'b1;
    redirect_pc_i = 16'hC000;
    redirect_valid_i = 1'b1;
    @(negedge clk);
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    check("redir_hs_req", {instr_valid_o, mem_req_o, mem_addr_o}, {2'b01, 16'hC000});
    wait_valid("redir_hs");
    check("redir_hs_pc", 64'(instr_pc_o), 64'hC000);

    // Reset in the middle of a fetch
    mem[16'h8000] = 8'hEA;
    redirect_to(16'hA000);
    repeat (2) @(negedge clk);
    do_reset("midrst");
    wait_valid("midrst");
    check("midrst_bundle", 64'(dut_bundle()), 64'(pack(8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000, 1'b0)));

    // Random stream against the reference model
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      if (TRAP && b[1:0] == 2'b11) b[0] = 1'b0;
      mem[i] = b;
    end
    do_reset("rand");
    ref_pc = 16'h8000;
    hs = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 49) == 0);
      tgt = 16'($urandom);
      if (instr_valid_o && rdy) begin
        p1 = ref_pc + 16'd1;
        p2 = ref_pc + 16'd2;
        eo = mem[ref_pc];
        l  = ref_len(int'(eo));
        ea = (l >= 2) ? mem[p1] : 8'h00;
        eb = (l == 3) ? mem[p2] : 8'h00;
        check($sformatf("rand_hs%0d", hs), {20'd0, mem_req_o, dut_bundle()},
              {20'd0, 1'b0, pack(eo, ea, eb, 2'(l), ref_pc, 1'b0)});
        ref_pc = ref_pc + 16'(l);
        hs++;
      end
      if (rd) ref_pc = tgt;
      instr_ready_i    = rdy;
      redirect_valid_i = rd;
      redirect_pc_i    = tgt;
      @(negedge clk);
    end
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    check("rand_progress", 64'(hs > 300), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
